// File: rtl/lpif_dstrm_lane_serializer_pkg.sv
// Shared types for the dstrm lane serializer: lane geometry, the 76-bit lane
// flit record and a helper that slices one lane out of the 4-lane dstrm bus.
package lpif_dstrm_pkg;

  localparam int LANES    = 4;
  localparam int LANE_DW  = 64;
  localparam int STATE_W  = 4;
  localparam int PROTID_W = 2;
  localparam int CRC_W    = 4;
  localparam int OFF_W    = $clog2(LANES);
  localparam int CNT_W    = $clog2(LANES + 1);

  typedef struct packed {
    logic [STATE_W-1:0]  state;
    logic [PROTID_W-1:0] protid;
    logic [LANE_DW-1:0]  data;
    logic                dvalid;
    logic [CRC_W-1:0]    crc;
    logic                crc_valid;
  } lane_flit_t;

  typedef struct packed {
    logic [LANES*STATE_W-1:0]  state;
    logic [LANES*PROTID_W-1:0] protid;
    logic [LANES*LANE_DW-1:0]  data;
    logic [LANES-1:0]          dvalid;
    logic [LANES*CRC_W-1:0]    crc;
    logic [LANES-1:0]          crc_valid;
  } dstrm_bus_t;

  // Shifts rather than part-selects so a runtime lane index stays width-clean.
  function automatic lane_flit_t unpack_dstrm_lane(input dstrm_bus_t bus, input int unsigned i);
    lane_flit_t f;
    f.state     = STATE_W'(bus.state >> (STATE_W * i));
    f.protid    = PROTID_W'(bus.protid >> (PROTID_W * i));
    f.data      = LANE_DW'(bus.data >> (LANE_DW * i));
    f.dvalid    = 1'(bus.dvalid >> i);
    f.crc       = CRC_W'(bus.crc >> (CRC_W * i));
    f.crc_valid = 1'(bus.crc_valid >> i);
    return f;
  endfunction

endpackage

// File: rtl/lpif_dstrm_lane_serializer_if.sv
// Bus bundle between the slave top's user side and the serializer: 4-lane
// dstrm input word plus the single-lane pl_* output stream with its ready.
interface lpif_dstrm_lane_serializer_if;
  import lpif_dstrm_pkg::*;

  logic [LANES*STATE_W-1:0]  dstrm_state;
  logic [LANES*PROTID_W-1:0] dstrm_protid;
  logic [LANES*LANE_DW-1:0]  dstrm_data;
  logic [LANES-1:0]          dstrm_dvalid;
  logic [LANES*CRC_W-1:0]    dstrm_crc;
  logic [LANES-1:0]          dstrm_crc_valid;
  logic [LANES-1:0]          dstrm_valid;

  logic [STATE_W-1:0]        pl_state;
  logic [PROTID_W-1:0]       pl_protid;
  logic [LANE_DW-1:0]        pl_data;
  logic                      pl_dvalid;
  logic [CRC_W-1:0]          pl_crc;
  logic                      pl_crc_valid;
  logic                      pl_valid;
  logic                      pl_ready;

  modport master (
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
           dstrm_crc, dstrm_crc_valid, dstrm_valid, pl_ready,
    input  pl_state, pl_protid, pl_data, pl_dvalid, pl_crc, pl_crc_valid, pl_valid
  );

  modport slave (
    input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
           dstrm_crc, dstrm_crc_valid, dstrm_valid, pl_ready,
    output pl_state, pl_protid, pl_data, pl_dvalid, pl_crc, pl_crc_valid, pl_valid
  );

endinterface

// File: rtl/lpif_dstrm_lane_serializer_compact.sv
// Lane compaction: per-lane write offset (count of valid lanes below it) and
// the total number of valid lanes in the dstrm word.
module lpif_lane_compact
  import lpif_dstrm_pkg::*;
(
  input  logic [LANES-1:0]            lane_valid,
  output logic [LANES-1:0][OFF_W-1:0] lane_offset,
  output logic [CNT_W-1:0]            lane_count
);

  // Running prefix popcount, lowest lane first.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc         = '0;
    lane_offset = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_offset[i] = OFF_W'(acc);
      acc            = acc + CNT_W'(lane_valid[i]);
    end
    lane_count = acc;
  end

endmodule

// File: rtl/lpif_dstrm_lane_serializer.sv
// Serializes the 4-lane dstrm bus into one lane flit per cycle through an
// in-order FIFO. Whole words are admitted or dropped; link loss flushes.
module lpif_dstrm_lane_serializer
  import lpif_dstrm_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int FW   = $clog2(DEPTH + 1)
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  input  logic                          rx_online,
  input  logic                          clr_status,
  lpif_dstrm_lane_serializer_if.slave   bus,
  output logic [FW-1:0]                 fill_level,
  output logic                          ovf_sticky,
  output logic [7:0]                    drop_cnt
);

  dstrm_bus_t                dbus;
  lane_flit_t                lane_flit [LANES];
  lane_flit_t                mem [DEPTH];
  lane_flit_t                head;
  logic [LANES-1:0][OFF_W-1:0] lane_offset;
  logic [CNT_W-1:0]          lane_count;
  logic [CNT_W-1:0]          n_in;
  logic [CNT_W-1:0]          n_push;
  logic [FW-1:0]             free_slots;
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      drop;
  logic                      pop;
  logic                      pl_valid_int;

  assign dbus = {bus.dstrm_state, bus.dstrm_protid, bus.dstrm_data,
                 bus.dstrm_dvalid, bus.dstrm_crc, bus.dstrm_crc_valid};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_flit[g] = unpack_dstrm_lane(dbus, g);
  end

  lpif_lane_compact u_compact (
    .lane_valid  (bus.dstrm_valid),
    .lane_offset (lane_offset),
    .lane_count  (lane_count)
  );

  // Free space is judged before this cycle's pop, so a full FIFO being drained
  // still refuses a word this cycle.
  assign free_slots   = FW'(DEPTH) - fill_level;
  assign n_in         = rx_online ? lane_count : '0;
  assign drop         = FW'(n_in) > free_slots;
  assign n_push       = drop ? '0 : n_in;
  assign pl_valid_int = (fill_level != '0);
  assign pop          = rx_online && pl_valid_int && bus.pl_ready;

  // Storage write: accepted lanes land contiguously starting at wr_ptr.
  always_ff @(posedge clk_wr) begin
    for (int i = 0; i < LANES; i++) begin
      if (rx_online && !drop && bus.dstrm_valid[i]) begin
        mem[wr_ptr + AW'(lane_offset[i])] <= lane_flit[i];
      end
    end
  end

  // Pointer and occupancy tracking; link loss clears them on the next edge.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else if (!rx_online) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(n_push);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fill_level <= fill_level + FW'(n_push) - FW'(pop);
    end
  end

  // Overflow status; a drop in the same cycle as a clear counts as the first new drop.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (clr_status) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (clr_status) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end
  end

  // Show-ahead head flit, masked to zero while the FIFO is empty.
  always_comb begin
    head = pl_valid_int ? mem[rd_ptr] : '0;
  end

  assign bus.pl_valid     = pl_valid_int;
  assign bus.pl_state     = head.state;
  assign bus.pl_protid    = head.protid;
  assign bus.pl_data      = head.data;
  assign bus.pl_dvalid    = head.dvalid;
  assign bus.pl_crc       = head.crc;
  assign bus.pl_crc_valid = head.crc_valid;

endmodule

// File: tb/tb_lpif_dstrm_lane_serializer.sv
// Directed bench for the dstrm lane serializer: ordering, lane compaction,
// whole-word admission at full, flush on link loss, status saturation/clear
// and asynchronous reset.
module tb_lpif_dstrm_lane_serializer;
  import lpif_dstrm_pkg::*;

  logic       clk_wr = 1'b0;
  logic       rst_wr_n;
  logic       rx_online;
  logic       clr_status;
  logic [4:0] fill_level;
  logic       ovf_sticky;
  logic [7:0] drop_cnt;
  int         compared   = 0;
  int         mismatched = 0;

  lpif_dstrm_lane_serializer_if bus ();

  lpif_dstrm_lane_serializer #(.DEPTH(16)) dut (
    .clk_wr     (clk_wr),
    .rst_wr_n   (rst_wr_n),
    .rx_online  (rx_online),
    .clr_status (clr_status),
    .bus        (bus),
    .fill_level (fill_level),
    .ovf_sticky (ovf_sticky),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane i carries data base+i and fixed side-band values derived from i.
  task automatic drive_word(input logic [3:0] v, input logic [63:0] base);
    for (int i = 0; i < 4; i++) begin
      bus.dstrm_data[64*i +: 64]    = base + 64'(i);
      bus.dstrm_state[4*i +: 4]     = 4'(i + 3);
      bus.dstrm_protid[2*i +: 2]    = 2'(3 - i);
      bus.dstrm_dvalid[i]           = i[0];
      bus.dstrm_crc[4*i +: 4]       = 4'(9 + i);
      bus.dstrm_crc_valid[i]        = ~i[0];
    end
    bus.dstrm_valid = v;
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  initial begin
    rst_wr_n             = 1'b0;
    rx_online            = 1'b0;
    clr_status           = 1'b0;
    bus.pl_ready         = 1'b0;
    bus.dstrm_valid      = '0;
    bus.dstrm_state      = '0;
    bus.dstrm_protid     = '0;
    bus.dstrm_data       = '0;
    bus.dstrm_dvalid     = '0;
    bus.dstrm_crc        = '0;
    bus.dstrm_crc_valid  = '0;
    repeat (3) tick();
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_valid", 64'(bus.pl_valid), 64'd0);
    chk("rst_data", bus.pl_data, 64'd0);
    chk("rst_ovf", 64'(ovf_sticky), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst_wr_n = 1'b1;

    // Full word in order, drained one flit per cycle.
    rx_online    = 1'b1;
    bus.pl_ready = 1'b1;
    drive_word(4'hF, 64'h10);
    tick();
    bus.dstrm_valid = '0;
    chk("t1_fill4", 64'(fill_level), 64'd4);
    chk("t1_d0", bus.pl_data, 64'h10);
    tick();
    chk("t1_d1", bus.pl_data, 64'h11);
    chk("t1_fill3", 64'(fill_level), 64'd3);
    tick();
    chk("t1_d2", bus.pl_data, 64'h12);
    tick();
    chk("t1_d3", bus.pl_data, 64'h13);
    chk("t1_fill1", 64'(fill_level), 64'd1);
    tick();
    chk("t1_empty", 64'(bus.pl_valid), 64'd0);
    chk("t1_mask", bus.pl_data, 64'd0);

    // Sparse lanes compact and keep their side-band fields.
    drive_word(4'b1010, 64'hA0);
    tick();
    bus.dstrm_valid = '0;
    chk("t2_fill2", 64'(fill_level), 64'd2);
    chk("t2_dA1", bus.pl_data, 64'hA1);
    chk("t2_st1", 64'(bus.pl_state), 64'h4);
    chk("t2_pid1", 64'(bus.pl_protid), 64'h2);
    chk("t2_crc1", 64'(bus.pl_crc), 64'hA);
    chk("t2_dv1", 64'(bus.pl_dvalid), 64'd1);
    chk("t2_cv1", 64'(bus.pl_crc_valid), 64'd0);
    tick();
    chk("t2_dA3", bus.pl_data, 64'hA3);
    chk("t2_st3", 64'(bus.pl_state), 64'h6);
    chk("t2_pid3", 64'(bus.pl_protid), 64'h0);
    chk("t2_crc3", 64'(bus.pl_crc), 64'hC);
    tick();
    chk("t2_empty", 64'(fill_level), 64'd0);

    // Fill to capacity, then one more word is dropped whole.
    bus.pl_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_word(4'hF, 64'h100 + 64'(4 * k));
      tick();
    end
    chk("t3_full", 64'(fill_level), 64'd16);
    chk("t3_nodrop", 64'(drop_cnt), 64'd0);
    chk("t3_noovf", 64'(ovf_sticky), 64'd0);
    chk("t3_hold", bus.pl_data, 64'h100);
    drive_word(4'b0001, 64'h200);
    tick();
    bus.dstrm_valid = '0;
    chk("t3_fill16", 64'(fill_level), 64'd16);
    chk("t3_ovf", 64'(ovf_sticky), 64'd1);
    chk("t3_drop1", 64'(drop_cnt), 64'd1);
    chk("t3_hold2", bus.pl_data, 64'h100);

    // Free space is taken before the pop: 3 lanes into 2 free drops.
    bus.pl_ready = 1'b1;
    tick();
    tick();
    chk("t4_fill14", 64'(fill_level), 64'd14);
    chk("t4_head", bus.pl_data, 64'h102);
    drive_word(4'b0111, 64'h300);
    tick();
    chk("t4_fill13", 64'(fill_level), 64'd13);
    chk("t4_drop2", 64'(drop_cnt), 64'd2);
    chk("t4_head2", bus.pl_data, 64'h103);
    // Exactly-fits word is accepted.
    bus.pl_ready = 1'b0;
    tick();
    bus.dstrm_valid = '0;
    chk("t4_fit", 64'(fill_level), 64'd16);
    chk("t4_fit_drop", 64'(drop_cnt), 64'd2);

    // Drain to 6, then link loss flushes without counting a drop.
    bus.pl_ready = 1'b1;
    repeat (10) tick();
    chk("t5_fill6", 64'(fill_level), 64'd6);
    chk("t5_head", bus.pl_data, 64'h10D);
    bus.pl_ready = 1'b0;
    rx_online    = 1'b0;
    drive_word(4'hF, 64'h400);
    tick();
    chk("t5_flush", 64'(fill_level), 64'd0);
    chk("t5_valid", 64'(bus.pl_valid), 64'd0);
    chk("t5_drop", 64'(drop_cnt), 64'd2);
    chk("t5_ovf", 64'(ovf_sticky), 64'd1);
    rx_online       = 1'b1;
    bus.dstrm_valid = '0;
    bus.pl_ready    = 1'b1;
    tick();
    chk("t5_rdy_empty", 64'(fill_level), 64'd0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t5_clr_ovf", 64'(ovf_sticky), 64'd0);
    chk("t5_clr_drop", 64'(drop_cnt), 64'd0);

    // Drop counter saturation, clear, and clear colliding with a drop.
    bus.pl_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_word(4'hF, 64'h500 + 64'(4 * k));
      tick();
    end
    drive_word(4'hF, 64'h600);
    repeat (300) tick();
    chk("t6_sat", 64'(drop_cnt), 64'hFF);
    chk("t6_full", 64'(fill_level), 64'd16);
    bus.dstrm_valid = '0;
    clr_status      = 1'b1;
    tick();
    chk("t6_clr", 64'(drop_cnt), 64'd0);
    drive_word(4'b0001, 64'h700);
    tick();
    clr_status = 1'b0;
    chk("t6_clr_drop", 64'(drop_cnt), 64'd1);
    chk("t6_clr_ovf", 64'(ovf_sticky), 64'd1);
    bus.pl_ready = 1'b1;
    drive_word(4'hF, 64'h800);
    tick();
    chk("t6_prepop_drop", 64'(drop_cnt), 64'd2);
    chk("t6_fill15", 64'(fill_level), 64'd15);
    #3;
    rst_wr_n = 1'b0;
    #1;
    chk("t6_rst_fill", 64'(fill_level), 64'd0);
    chk("t6_rst_valid", 64'(bus.pl_valid), 64'd0);
    chk("t6_rst_data", bus.pl_data, 64'd0);
    chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
    chk("t6_rst_ovf", 64'(ovf_sticky), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
